fft_twiddle_mult: RTL and testbench

Streaming twiddle-factor multiplier for the 16-point radix-2 FFT. Sits directly downstream of a butterfly stage, multiplies each complex sample by W = c + j·s (s = −sin) using the 3-multiplier form. Twiddle words come from the external cosine, cos+sin and cos−sin ROMs, which this block addresses. Q1.7 fixed point, valid/ready stream on both sides.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_twiddle_mult_if.sv | 32 +++
 rtl/fft_cmul3.sv | 106 ++++++++++
 rtl/fft_twiddle_mult.sv | 61 ++++++
 tb/tb_fft_twiddle_mult.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared widths, fixed-point constants and the rounding/saturation helper
// used by the twiddle multiplier.
package fft_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned COEF_W    = 8;
  localparam int unsigned SUMCOEF_W = 9;
  localparam int unsigned Q_SHIFT   = 7;
  localparam int unsigned TW_DEPTH  = 8;
  localparam int unsigned TW_ADDR_W = $clog2(TW_DEPTH);
  localparam int unsigned TW_WORD_W = 16;
  localparam int unsigned SUM_W     = DATA_W + 1;
  localparam int unsigned PROD_W    = 18;
  localparam int unsigned ACC_W     = 19;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (Q_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(SAT_MIN);

  // Round half-up, drop the Q1.7 fraction, clamp into the output range.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] r;
    r = (x + RND_HALF) >>> Q_SHIFT;
    if (r > SAT_HI) begin
      r = SAT_HI;
    end else if (r < SAT_LO) begin
      r = SAT_LO;
    end
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fft_twiddle_mult_if.sv
// Stream-in / stream-out / twiddle ROM bundle for the twiddle multiplier.
interface fft_twiddle_mult_if;
  import fft_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATA_W-1:0]    in_re;
  logic signed [DATA_W-1:0]    in_im;
  logic                        in_last;
  logic [TW_ADDR_W-1:0]        tw_addr;
  logic [TW_WORD_W-1:0]        tw_c;
  logic [TW_WORD_W-1:0]        tw_cps;
  logic [TW_WORD_W-1:0]        tw_cms;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATA_W-1:0]    out_re;
  logic signed [DATA_W-1:0]    out_im;
  logic                        out_last;

  // Multiplier side.
  modport slave (
    input  in_valid, in_re, in_im, in_last, tw_c, tw_cps, tw_cms, out_ready,
    output in_ready, tw_addr, out_valid, out_re, out_im, out_last
  );

  // Upstream source / ROMs / downstream sink side.
  modport master (
    output in_valid, in_re, in_im, in_last, tw_c, tw_cps, tw_cms, out_ready,
    input  in_ready, tw_addr, out_valid, out_re, out_im, out_last
  );

endinterface

// File: rtl/fft_cmul3.sv
// Three-stage complex multiply (a+jb)(c+js) using the 3-multiplier form:
// re = c(a+b) - b(c+s), im = c(a+b) - a(c-s). All stages advance on en_i.
module fft_cmul3
  import fft_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  input  logic signed [DATA_W-1:0]    a_i,
  input  logic signed [DATA_W-1:0]    b_i,
  input  logic signed [COEF_W-1:0]    c_i,
  input  logic signed [SUMCOEF_W-1:0] cps_i,
  input  logic signed [SUMCOEF_W-1:0] cms_i,
  output logic                        valid_o,
  output logic                        last_o,
  output logic signed [DATA_W-1:0]    re_o,
  output logic signed [DATA_W-1:0]    im_o
);

  logic                        v1_q, l1_q;
  logic signed [DATA_W-1:0]    a1_q, b1_q;
  logic signed [SUM_W-1:0]     sum1_d, sum1_q;
  logic signed [COEF_W-1:0]    c1_q;
  logic signed [SUMCOEF_W-1:0] cps1_q, cms1_q;

  logic                        v2_q, l2_q;
  logic signed [PROD_W-1:0]    m1_d, m2_d, m3_d, m1_q, m2_q, m3_q;

  logic                        v3_q, l3_q;
  logic signed [DATA_W-1:0]    re_d, im_d, re_q, im_q;

  // Datapath arithmetic feeding each register stage.
  always_comb begin
    sum1_d = SUM_W'(a_i) + SUM_W'(b_i);
    m1_d   = PROD_W'(c1_q) * PROD_W'(sum1_q);
    m2_d   = PROD_W'(b1_q) * PROD_W'(cps1_q);
    m3_d   = PROD_W'(a1_q) * PROD_W'(cms1_q);
    re_d   = round_sat(ACC_W'(m1_q) - ACC_W'(m2_q));
    im_d   = round_sat(ACC_W'(m1_q) - ACC_W'(m3_q));
  end

  // Stage 1: capture operands, pre-add and twiddle words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      l1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      sum1_q <= '0;
      c1_q   <= '0;
      cps1_q <= '0;
      cms1_q <= '0;
    end else if (en_i) begin
      v1_q   <= valid_i;
      l1_q   <= last_i;
      a1_q   <= a_i;
      b1_q   <= b_i;
      sum1_q <= sum1_d;
      c1_q   <= c_i;
      cps1_q <= cps_i;
      cms1_q <= cms_i;
    end
  end

  // Stage 2: the three products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      m1_q <= '0;
      m2_q <= '0;
      m3_q <= '0;
    end else if (en_i) begin
      v2_q <= v1_q;
      l2_q <= l1_q;
      m1_q <= m1_d;
      m2_q <= m2_d;
      m3_q <= m3_d;
    end
  end

  // Stage 3: combine, round, saturate; data only refreshes on a real sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      l3_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else if (en_i) begin
      v3_q <= v2_q;
      if (v2_q) begin
        l3_q <= l2_q;
        re_q <= re_d;
        im_q <= im_d;
      end
    end
  end

  assign valid_o = v3_q;
  assign last_o  = l3_q;
  assign re_o    = re_q;
  assign im_o    = im_q;

endmodule

// File: rtl/fft_twiddle_mult.sv
// Streaming twiddle multiplier: twiddle address counter and valid/ready
// handshake around the pipelined 3-multiplier datapath.
module fft_twiddle_mult
  import fft_pkg::*;
#(
  parameter int unsigned STRIDE = 1
) (
  input logic               clk,
  input logic               rst_n,
  fft_twiddle_mult_if.slave bus_io
);

  logic                 stall;
  logic                 en;
  logic                 accept;
  logic                 out_valid;
  logic [TW_ADDR_W-1:0] tw_addr_d, tw_addr_q;

  // Whole pipe freezes while the output is held; last sample of a frame
  // restarts the twiddle sequence at index 0.
  always_comb begin
    stall     = out_valid & ~bus_io.out_ready;
    en        = ~stall;
    accept    = bus_io.in_valid & en;
    tw_addr_d = tw_addr_q;
    if (accept) begin
      tw_addr_d = bus_io.in_last ? '0 : tw_addr_q + TW_ADDR_W'(STRIDE);
    end
  end

  // Twiddle address register; moves only on accept edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_addr_q <= '0;
    end else begin
      tw_addr_q <= tw_addr_d;
    end
  end

  fft_cmul3 u_cmul3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (bus_io.in_valid),
    .last_i  (bus_io.in_last),
    .a_i     (bus_io.in_re),
    .b_i     (bus_io.in_im),
    .c_i     (bus_io.tw_c[COEF_W-1:0]),
    .cps_i   (bus_io.tw_cps[SUMCOEF_W-1:0]),
    .cms_i   (bus_io.tw_cms[SUMCOEF_W-1:0]),
    .valid_o (out_valid),
    .last_o  (bus_io.out_last),
    .re_o    (bus_io.out_re),
    .im_o    (bus_io.out_im)
  );

  assign bus_io.in_ready  = en;
  assign bus_io.tw_addr   = tw_addr_q;
  assign bus_io.out_valid = out_valid;

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Bench for fft_twiddle_mult: directed vectors, stride/frame sequencing,
// backpressure, random traffic and mid-flight reset.
module tb_fft_twiddle_mult;
  import fft_pkg::*;

  localparam int STRIDE = 2;

  typedef struct { int re; int im; bit last; } res_t;
  typedef struct { int a; int b; bit last; int addr; int re; int im; } vec_t;

  logic clk;
  logic rst_n;

  fft_twiddle_mult_if bus ();

  fft_twiddle_mult #(.STRIDE(STRIDE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  // Q1.7 twiddles W16^k, k = 0..7: c = cos, s = -sin, truncated toward zero.
  int rom_c [8] = '{127, 117, 89, 48, 0, -48, -89, -117};
  int rom_s [8] = '{0, -48, -89, -117, -127, -117, -89, -48};

  res_t exp_q[$];
  res_t got_q[$];
  int   total = 0;
  int   bad = 0;
  int   model_addr = 0;
  bit   rand_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ROMs; upper word bits carry junk that must be ignored.
  always_comb begin
    bus.tw_c   = {8'h5A, 8'(rom_c[bus.tw_addr])};
    bus.tw_cps = {7'h2B, 9'(rom_c[bus.tw_addr] + rom_s[bus.tw_addr])};
    bus.tw_cms = {7'h55, 9'(rom_c[bus.tw_addr] - rom_s[bus.tw_addr])};
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting, expected the event", name);
  endtask

  function automatic int rsat(input int x);
    int r;
    r = (x + 64) >>> 7;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // Reference: exact complex product (a+jb)(c+js), then Q1.7 round/saturate.
  function automatic void model_push(input int a, input int b, input bit last);
    res_t e;
    int   c;
    int   s;
    c = rom_c[model_addr];
    s = rom_s[model_addr];
    e.re   = rsat(a * c - b * s);
    e.im   = rsat(a * s + b * c);
    e.last = last;
    exp_q.push_back(e);
    model_addr = last ? 0 : (model_addr + STRIDE) % 8;
  endfunction

  // Present one sample and wait until it will be taken on the next edge.
  task automatic send(input int a, input int b, input bit last, output int addr_seen);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_re    = 8'(a);
    bus.in_im    = 8'(b);
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        fail_timeout("send_in_ready");
        break;
      end
    end
    addr_seen = int'(bus.tw_addr);
    chk("tw_addr_at_accept", addr_seen, model_addr);
    model_push(a, b, last);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_timeout("drain");
    repeat (2) @(negedge clk);
  endtask

  // Output monitor: scoreboard compare, capture, and hold-under-stall check.
  initial begin
    res_t held;
    res_t e;
    res_t g;
    bit   hold_chk;
    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          chk("hold_out_valid", int'(bus.out_valid), 1);
          chk("hold_out_re", int'(bus.out_re), held.re);
          chk("hold_out_im", int'(bus.out_im), held.im);
          chk("hold_out_last", int'(bus.out_last), int'(held.last));
        end
        if (bus.out_valid && bus.out_ready) begin
          g = '{int'(bus.out_re), int'(bus.out_im), bus.out_last};
          got_q.push_back(g);
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", int'(bus.out_valid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("model_re", g.re, e.re);
            chk("model_im", g.im, e.im);
            chk("model_last", int'(g.last), int'(e.last));
          end
        end
        hold_chk = bus.out_valid && !bus.out_ready;
        held     = '{int'(bus.out_re), int'(bus.out_im), bus.out_last};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    int   stride_exp [10] = '{0, 2, 4, 6, 0, 0, 2, 4, 6, 0};
    int   lat;
    int   addr;
    int   a;
    int   b;

    tbl[0] = '{100, -50, 1'b0, 0, 99, -50};
    tbl[1] = '{-128, -128, 1'b0, 2, -128, 0};
    tbl[2] = '{64, 0, 1'b0, 4, 0, -63};
    tbl[3] = '{10, 20, 1'b0, 6, 7, -21};
    tbl[4] = '{-1, 1, 1'b1, 0, -1, 1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_re", int'(bus.out_re), 0);
    chk("rst_out_im", int'(bus.out_im), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_tw_addr", int'(bus.tw_addr), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rst_in_ready", int'(bus.in_ready), 1);

    // Accept-to-output latency with a frame-ending sample at address 0.
    send(100, -50, 1'b1, addr);
    idle();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    chk("lat_out_re", int'(bus.out_re), 99);
    chk("lat_out_im", int'(bus.out_im), -50);
    drain();

    // Directed table, back to back.
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].last, addr);
      chk("tbl_addr", addr, tbl[i].addr);
    end
    idle();
    drain();
    chk("tbl_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) begin
        chk("tbl_re", got_q[i].re, tbl[i].re);
        chk("tbl_im", got_q[i].im, tbl[i].im);
        chk("tbl_last", int'(got_q[i].last), int'(tbl[i].last));
      end
    end

    // Stride-2 sequence with a frame boundary on the 5th sample.
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      send(a, b, (i == 4), addr);
      chk("stride_addr", addr, stride_exp[i]);
    end
    idle();
    drain();
    chk("stride_count", got_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < got_q.size()) chk("stride_out_last", int'(got_q[i].last), (i == 4) ? 1 : 0);
    end

    // Backpressure: hold the output for 4 cycles with the pipe full.
    got_q.delete();
    fork
      begin
        int sa;
        for (int i = 0; i < 8; i++) begin
          send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               1'b0, sa);
        end
        idle();
      end
      begin
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (!bus.out_valid) fail_timeout("stall_fill");
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", got_q.size(), 8);

    // Random traffic, random gaps and random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          a = int'($urandom_range(0, 255)) - 128;
          b = int'($urandom_range(0, 255)) - 128;
          send(a, b, ($urandom_range(0, 7) == 0), addr);
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
          end
        end
        send(1, 1, 1'b1, addr);
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three samples in flight.
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b0, addr);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #2;
    chk("pre_reset_out_valid", int'(bus.out_valid), 1);
    chk("pre_reset_tw_addr", int'(bus.tw_addr), 6);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(bus.out_valid), 0);
    chk("async_rst_tw_addr", int'(bus.tw_addr), 0);
    chk("async_rst_out_re", int'(bus.out_re), 0);
    chk("async_rst_out_im", int'(bus.out_im), 0);
    exp_q.delete();
    model_addr = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    send(50, -20, 1'b0, addr);
    chk("post_reset_addr", addr, 0);
    idle();
    drain();
    chk("post_reset_count", got_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
